// File: rtl/stdp_update_sched.sv
// stdp_update_sched
//   After each time step, applies one pass of pair-based STDP weight updates
//   to the weight RAM owned by snn_core. On an accepted start it latches the
//   step's spike bits and walks every synapse address f*N+n (f outer, n inner).
//   Each touched synapse takes one read-modify-write with clamping.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   start, enable           pass request (accepted only when enable=1 and idle)
//   pre_bits, post_bits     spikes of the finished step, latched on start
//   eta, b_pre, b_post      Q1.14 potentiation / depression magnitudes
//   eta_shift               arithmetic right shift of raw delta (capped at 17)
//   en_pre, en_post         gates for the b_pre / b_post terms
//   wmin, wmax              clamp bounds (wmin wins if wmin > wmax)
//   mem_re/mem_we/mem_addr  RAM strobes and address; read data valid next cycle
//   mem_wdata, mem_rdata    RAM write / read data
//   busy, done, wr_count    status: busy in RD/WR/FIN, done pulse in FIN,
//                           saturating write count of the current/last pass
//
// Build option
//   STDP_SKIP_IDLE_EN  when defined, synapses with no pre and no post spike
//                      are skipped in a single RD cycle without RAM access.
module stdp_update_sched #(
  parameter  int F  = 48,
  parameter  int N  = 96,
  localparam int AW = $clog2(F*N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 enable,
  input  logic [F-1:0]         pre_bits,
  input  logic [N-1:0]         post_bits,
  input  logic signed [15:0]   eta,
  input  logic signed [15:0]   b_pre,
  input  logic signed [15:0]   b_post,
  input  logic [7:0]           eta_shift,
  input  logic                 en_pre,
  input  logic                 en_post,
  input  logic signed [15:0]   wmin,
  input  logic signed [15:0]   wmax,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic signed [15:0]   mem_wdata,
  input  logic signed [15:0]   mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          wr_count
);

  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(F - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [F-1:0]        r_pre;
  logic [N-1:0]        r_post;
  logic [FW-1:0]       r_f;
  logic [NW-1:0]       r_n;
  logic [AW-1:0]       r_addr;
  logic [15:0]         r_wr_count;

  logic                w_p;
  logic                w_q;
  logic                w_last;
  logic                w_skip;
  logic                w_accept;
  logic                w_adv;
  logic signed [17:0]  w_raw;
  logic signed [17:0]  w_delta;
  logic signed [17:0]  w_sum;
  logic signed [15:0]  w_new;

  function automatic logic signed [17:0] f_sext18(input logic signed [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  // The three terms are mutually exclusive in (p,q), so at most one applies.
  function automatic logic signed [17:0] f_raw_delta(
    input logic p, input logic q, input logic gate_pre, input logic gate_post,
    input logic signed [15:0] pot, input logic signed [15:0] dep_pre,
    input logic signed [15:0] dep_post);
    logic signed [17:0] r;
    r = 18'sd0;
    if (p & q)                r = f_sext18(pot);
    if (gate_post & q & ~p)   r = r - f_sext18(dep_post);
    if (gate_pre  & p & ~q)   r = r - f_sext18(dep_pre);
    return r;
  endfunction

  function automatic logic [4:0] f_shamt(input logic [7:0] s);
    return (s > 8'd17) ? 5'd17 : s[4:0];
  endfunction

  // Inverted bounds collapse to wmin.
  function automatic logic signed [15:0] f_clamp(input logic signed [17:0] sum,
    input logic signed [15:0] lo, input logic signed [15:0] hi);
    logic signed [17:0] lo18;
    logic signed [17:0] hi18;
    lo18 = f_sext18(lo);
    hi18 = f_sext18(hi);
    if (lo > hi)          return lo;
    else if (sum < lo18)  return lo;
    else if (sum > hi18)  return hi;
    else                  return sum[15:0];
  endfunction

  assign w_p     = r_pre[r_f];
  assign w_q     = r_post[r_n];
  assign w_last  = (r_f == F_LAST) && (r_n == N_LAST);

`ifdef STDP_SKIP_IDLE_EN
  assign w_skip  = ~w_p & ~w_q;
`else
  assign w_skip  = 1'b0;
`endif

  assign w_raw   = f_raw_delta(w_p, w_q, en_pre, en_post, eta, b_pre, b_post);
  assign w_delta = w_raw >>> f_shamt(eta_shift);
  assign w_sum   = f_sext18(mem_rdata) + w_delta;
  assign w_new   = f_clamp(w_sum, wmin, wmax);

  assign mem_addr = r_addr;
  assign wr_count = r_wr_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    w_accept  = 1'b0;
    w_adv     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && enable) begin
          w_accept = 1'b1;
          w_next   = S_RD;
        end
      end
      S_RD: begin
        busy = 1'b1;
        if (w_skip) begin
          w_adv  = 1'b1;
          w_next = w_last ? S_FIN : S_RD;
        end else begin
          mem_re = 1'b1;
          w_next = S_WR;
        end
      end
      S_WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = w_new;
        w_adv     = 1'b1;
        w_next    = w_last ? S_FIN : S_RD;
      end
      S_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Index and address advance together; the address is kept as a running
  // count rather than multiplied out, and is left in place after the last one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre      <= '0;
      r_post     <= '0;
      r_f        <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_accept) begin
        r_pre  <= pre_bits;
        r_post <= post_bits;
        r_f    <= '0;
        r_n    <= '0;
        r_addr <= '0;
      end else if (w_adv && !w_last) begin
        if (r_n == N_LAST) begin
          r_n <= '0;
          r_f <= r_f + 1'b1;
        end else begin
          r_n <= r_n + 1'b1;
        end
        r_addr <= r_addr + 1'b1;
      end
      if (w_accept)
        r_wr_count <= '0;
      else if (mem_we && (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_stdp_update_sched.sv
module tb_stdp_update_sched;
  localparam int F  = 2;
  localparam int N  = 3;
  localparam int AW = 3;
  localparam int NS = F * N;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic                clk = 1'b0;
  logic                rstn;
  logic                start;
  logic                enable;
  logic [F-1:0]        pre_bits;
  logic [N-1:0]        post_bits;
  logic signed [15:0]  eta;
  logic signed [15:0]  b_pre;
  logic signed [15:0]  b_post;
  logic [7:0]          eta_shift;
  logic                en_pre;
  logic                en_post;
  logic signed [15:0]  wmin;
  logic signed [15:0]  wmax;
  logic                mem_re;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic signed [15:0]  mem_wdata;
  logic signed [15:0]  mem_rdata;
  logic                busy;
  logic                done;
  logic [15:0]         wr_count;

  logic [15:0]         mem [NS];
  logic [15:0]         ld_val [NS];
  logic                load_req;

  wr_t                 exp_q[$];
  wr_t                 obs_q[$];
  int                  n_vec = 0;
  int                  n_bad = 0;

  always #5 clk = ~clk;

  stdp_update_sched #(.F(F), .N(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .enable(enable),
    .pre_bits(pre_bits), .post_bits(post_bits),
    .eta(eta), .b_pre(b_pre), .b_post(b_post), .eta_shift(eta_shift),
    .en_pre(en_pre), .en_post(en_post), .wmin(wmin), .wmax(wmax),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  // Weight RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NS; i++) mem[i] <= ld_val[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [15:0] m_upd(input logic [15:0] w, input bit p, input bit q);
    int raw, sh, sum, lo, hi;
    lo  = int'(wmin);
    hi  = int'(wmax);
    raw = 0;
    if (p && q)                  raw = int'(eta);
    else if (q && !p && en_post) raw = -int'(b_post);
    else if (p && !q && en_pre)  raw = -int'(b_pre);
    sh  = (eta_shift > 8'd17) ? 17 : int'(eta_shift);
    sum = int'($signed(w)) + (raw >>> sh);
    if (lo > hi)  return 16'(lo);
    if (sum < lo) return 16'(lo);
    if (sum > hi) return 16'(hi);
    return 16'(sum);
  endfunction

  task automatic load_mem();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Expected write sequence and cycle count from accept edge to FIN.
  task automatic build_exp(output int ek, output int ecnt);
    wr_t t;
    exp_q.delete();
    ek = 0;
    ecnt = 0;
    for (int f = 0; f < F; f++) begin
      for (int n = 0; n < N; n++) begin
        bit p, q, sk;
        p = pre_bits[f];
        q = post_bits[n];
`ifdef STDP_SKIP_IDLE_EN
        sk = !p && !q;
`else
        sk = 1'b0;
`endif
        if (sk) ek += 1;
        else begin
          ek += 2;
          ecnt++;
          t.a = AW'(f * N + n);
          t.d = m_upd(ld_val[f * N + n], p, q);
          exp_q.push_back(t);
        end
      end
    end
  endtask

  // Starts a pass and records strobes until done (no checking here).
  task automatic drive_pass(input int restart_at, output int k, output int ovl,
                            output bit tmo);
    wr_t t;
    obs_q.delete();
    ovl = 0;
    tmo = 1'b0;
    k = 0;
    enable = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1) begin
      if (mem_re && mem_we) ovl++;
      if (mem_we) begin
        t.a = mem_addr;
        t.d = mem_wdata;
        obs_q.push_back(t);
      end
      if (k == restart_at) begin
        start = 1'b1;
        pre_bits = '1;
        post_bits = '1;
      end else start = 1'b0;
      @(posedge clk); #1;
      k++;
      if (k > 100) begin tmo = 1'b1; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 0; enable = 0; pre_bits = 0; post_bits = 0;
    eta = 0; b_pre = 0; b_post = 0; eta_shift = 0; en_pre = 0; en_post = 0;
    wmin = 0; wmax = 0; load_req = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({mem_re, mem_we, mem_addr, mem_wdata, busy, done, wr_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got re=%b we=%b addr=%0d wd=%h busy=%b done=%b cnt=%0d want all 0",
               mem_re, mem_we, mem_addr, mem_wdata, busy, done, wr_count);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    int k, ovl, ek, ec;
    bit tmo;
    wr_t e, o;
    ld_val = '{16'h3F80, 16'h0100, 16'hFF00, 16'h0200, 16'h1000, 16'hF000};
    load_mem();
    pre_bits = 2'b01; post_bits = 3'b001; eta = 16'sh0100; eta_shift = 0;
    en_pre = 0; en_post = 0; b_pre = 0; b_post = 0;
    wmin = -16'sh4000; wmax = 16'sh4000;
    build_exp(ek, ec);
    drive_pass(-1, k, ovl, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL clamp_timeout no done within bound"); end
    n_vec++; if (k != ek) begin n_bad++; $display("FAIL clamp_done_cycle got %0d want %0d", k, ek); end
    n_vec++; if (ovl != 0) begin n_bad++; $display("FAIL clamp_re_we_overlap got %0d want 0", ovl); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clamp_busy_at_done got %b want 1", busy); end
    n_vec++; if (wr_count !== 16'(ec)) begin n_bad++; $display("FAIL clamp_wr_count got %0d want %0d", wr_count, ec); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL clamp_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin n_bad++; $display("FAIL clamp_write got a=%0d d=%h want a=%0d d=%h", o.a, o.d, e.a, e.d); end
    end
    n_vec++; if (mem[0] !== 16'h4000) begin n_bad++; $display("FAIL clamp_w0 got %h want 4000", mem[0]); end
    @(posedge clk); #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL clamp_idle_after got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_depression();
    int k, ovl, ek, ec;
    bit tmo;
    wr_t e, o;
    ld_val = '{default: 16'h0000};
    load_mem();
    pre_bits = 2'b10; post_bits = 3'b000; eta = 0; eta_shift = 8'd1;
    en_pre = 1; en_post = 0; b_pre = 16'sh0200; b_post = 0;
    wmin = -16'sh4000; wmax = 16'sh4000;
    build_exp(ek, ec);
    drive_pass(-1, k, ovl, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL dep_timeout no done within bound"); end
`ifdef STDP_SKIP_IDLE_EN
    n_vec++; if (k != 9) begin n_bad++; $display("FAIL dep_done_cycle got %0d want 9", k); end
    n_vec++; if (wr_count !== 16'd3) begin n_bad++; $display("FAIL dep_wr_count got %0d want 3", wr_count); end
`else
    n_vec++; if (k != 12) begin n_bad++; $display("FAIL dep_done_cycle got %0d want 12", k); end
    n_vec++; if (wr_count !== 16'd6) begin n_bad++; $display("FAIL dep_wr_count got %0d want 6", wr_count); end
`endif
    n_vec++; if (ovl != 0) begin n_bad++; $display("FAIL dep_re_we_overlap got %0d want 0", ovl); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL dep_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin n_bad++; $display("FAIL dep_write got a=%0d d=%h want a=%0d d=%h", o.a, o.d, e.a, e.d); end
    end
    for (int i = 3; i < 6; i++) begin
      n_vec++;
      if (mem[i] !== 16'hFF00) begin n_bad++; $display("FAIL dep_w%0d got %h want ff00", i, mem[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k, ovl, ek, ec;
    bit tmo;
    wr_t e, o;
    ld_val = '{16'h0011, 16'h0022, 16'hFF33, 16'h0044, 16'h8000, 16'h7FFF};
    load_mem();
    pre_bits = 2'b00; post_bits = 3'b000; eta = 16'sh0400; eta_shift = 0;
    en_pre = 1; en_post = 1; b_pre = 16'sh0100; b_post = 16'sh0100;
    wmin = -16'sh8000; wmax = 16'sh7FFF;
    build_exp(ek, ec);
    drive_pass(3, k, ovl, tmo);
    pre_bits = 0; post_bits = 0;
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL b2b_timeout no done within bound"); end
`ifdef STDP_SKIP_IDLE_EN
    n_vec++; if (k != 6) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 6", k); end
    n_vec++; if (wr_count !== 16'd0) begin n_bad++; $display("FAIL b2b_wr_count got %0d want 0", wr_count); end
`else
    n_vec++; if (k != 12) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 12", k); end
    n_vec++; if (wr_count !== 16'd6) begin n_bad++; $display("FAIL b2b_wr_count got %0d want 6", wr_count); end
`endif
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e || o.d !== ld_val[o.a]) begin
        n_bad++; $display("FAIL b2b_write got a=%0d d=%h want a=%0d d=%h", o.a, o.d, e.a, e.d);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_no_second_pass got busy=%b want 0", busy); end
  endtask

  task automatic test_gating();
    int k, ovl, ek, ec, strobes;
    bit tmo;
    wr_t e, o;
    ld_val = '{16'h1234, 16'hEDCB, 16'h0101, 16'h7F00, 16'h8001, 16'h0F0F};
    load_mem();
    pre_bits = 2'b00; post_bits = 3'b100; eta = 16'sh0300; eta_shift = 0;
    en_pre = 1; en_post = 0; b_pre = 16'sh0555; b_post = 16'sh1234;
    wmin = -16'sh8000; wmax = 16'sh7FFF;
    build_exp(ek, ec);
    drive_pass(-1, k, ovl, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL gate_timeout no done within bound"); end
    n_vec++; if (k != ek) begin n_bad++; $display("FAIL gate_done_cycle got %0d want %0d", k, ek); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL gate_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e || o.d !== ld_val[o.a]) begin
        n_bad++; $display("FAIL gate_write got a=%0d d=%h want a=%0d d=%h", o.a, o.d, e.a, e.d);
      end
    end
    @(posedge clk); #1;
    // Start with the master enable low must not begin a pass.
    enable = 1'b0; start = 1'b1; pre_bits = '1; post_bits = '1;
    @(posedge clk); #1;
    start = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy || mem_re || mem_we) strobes++;
      @(posedge clk); #1;
    end
    n_vec++; if (strobes != 0) begin n_bad++; $display("FAIL gate_enable_off got %0d active cycles want 0", strobes); end
    pre_bits = 0; post_bits = 0;
  endtask

  task automatic test_abort_wrap();
    int k, ovl, ek, ec, cyc, strobes;
    bit tmo, found;
    wr_t e, o;
    ld_val = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    load_mem();
    pre_bits = 2'b11; post_bits = 3'b111; eta = 16'sh0040; eta_shift = 0;
    en_pre = 1; en_post = 1; b_pre = 0; b_post = 0;
    wmin = -16'sh8000; wmax = 16'sh7FFF;
    enable = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (mem_we && mem_addr == 3'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (found !== 1'b1) begin n_bad++; $display("FAIL abort_reach_wr2 got none within 20 cycles want write to addr 2"); end
    rstn = 1'b0;
    #1;
    n_vec++;
    if ({mem_re, mem_we, mem_addr, mem_wdata, busy, done, wr_count} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs got re=%b we=%b addr=%0d busy=%b done=%b cnt=%0d want all 0",
               mem_re, mem_we, mem_addr, busy, done, wr_count);
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (mem_re || mem_we || busy) strobes++;
    end
    n_vec++; if (strobes != 0) begin n_bad++; $display("FAIL abort_strobes got %0d active cycles want 0", strobes); end
    n_vec++; if (mem[0] !== 16'h0140 || mem[1] !== 16'h0240 || mem[2] !== 16'h0300) begin
      n_bad++; $display("FAIL abort_mem got %h %h %h want 0140 0240 0300", mem[0], mem[1], mem[2]);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    load_mem();
    build_exp(ek, ec);
    drive_pass(-1, k, ovl, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout no done within bound"); end
    n_vec++; if (k != 12) begin n_bad++; $display("FAIL wrap_done_cycle got %0d want 12", k); end
    n_vec++; if (obs_q.size() != 6) begin n_bad++; $display("FAIL wrap_nwrites got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].a !== AW'(i)) begin n_bad++; $display("FAIL wrap_addr_seq got %0d want %0d", obs_q[i].a, i); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_write got a=%0d d=%h want a=%0d d=%h", o.a, o.d, e.a, e.d); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_inverted_bounds();
    int k, ovl, ek, ec;
    bit tmo;
    wr_t e, o;
    ld_val = '{16'h0000, 16'h0900, 16'hF000, 16'h7000, 16'h1000, 16'h0800};
    load_mem();
    pre_bits = 2'b01; post_bits = 3'b010; eta = 16'sh0100; eta_shift = 0;
    en_pre = 1; en_post = 1; b_pre = 16'sh0080; b_post = 16'sh0080;
    wmin = 16'sh1000; wmax = 16'sh0800;
    build_exp(ek, ec);
    drive_pass(-1, k, ovl, tmo);
    n_vec++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL inv_timeout no done within bound"); end
    n_vec++; if (k != ek) begin n_bad++; $display("FAIL inv_done_cycle got %0d want %0d", k, ek); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL inv_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e || o.d !== 16'h1000) begin
        n_bad++; $display("FAIL inv_write got a=%0d d=%h want a=%0d d=1000", o.a, o.d, e.a);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_depression();
    test_back_to_back();
    test_gating();
    test_abort_wrap();
    test_inverted_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stdp_update_sched.md
# stdp_update_sched

Sequencer that applies one pass of pair-based STDP weight updates to the `snn_core` weight RAM after each time step. On `start` it latches the step's pre/post spike bits and walks every synapse address `f*N+n` (f outer, n inner). For each touched synapse it does a read-modify-write with clamping, driving the core's `stdp_w_we/addr/wdata` and consuming `stdp_w_rdata`. It sits between the step controller and `snn_core`, which owns the RAM.

## Interface
Parameters:
- `F`, 48, number of pre-synaptic input features
- `N`, 96, number of neurons
- `AW`, `$clog2(F*N)`, weight address width (derived, do not override)

Ports:
- `clk  in  1`  clock
- `rstn  in  1`  reset, asynchronous, active-low
- `start  in  1`  single-cycle request to begin a pass; ignored unless `enable`=1 and FSM is IDLE
- `enable  in  1`  STDP master enable, sampled with `start`
- `pre_bits  in  F`  pre spikes of the finished step, latched on accepted start
- `post_bits  in  N`  post spikes of the finished step, latched on accepted start
- `eta  in  16 signed`  potentiation magnitude (Q1.14)
- `b_pre  in  16 signed`  depression magnitude for pre-without-post (Q1.14)
- `b_post  in  16 signed`  depression magnitude for post-without-pre (Q1.14)
- `eta_shift  in  8`  arithmetic right shift applied to raw delta, saturates at 17
- `en_pre  in  1`  gates the `b_pre` term
- `en_post  in  1`  gates the `b_post` term
- `wmin`, `wmax`  `in  16 signed`  clamp bounds
- `mem_re  out  1`  read strobe; `mem_rdata` is valid the following cycle
- `mem_we  out  1`  write strobe (to `stdp_w_we`)
- `mem_addr  out  AW`  address for both read and write
- `mem_wdata  out  16 signed`  write data
- `mem_rdata  in  16 signed`  read data (from `stdp_w_rdata`)
- `busy  out  1`  high in RD, WR, FIN
- `done  out  1`  single-cycle pulse in FIN
- `wr_count  out  16`  writes issued in the current or last pass, saturates at 0xFFFF

## Operation
- States are IDLE, RD, WR, FIN.
- **IDLE:** on `start & enable`, latch `pre_bits`/`post_bits`, set f=n=0, clear `wr_count`, and go to RD.
- **RD:** `mem_addr=f*N+n`.
  - If the synapse is skipped (see Configuration), assert nothing and advance the index. Go to FIN if this is the last index, otherwise stay in RD.
  - Otherwise assert `mem_re` and go to WR.
- **WR:** compute the new weight from `mem_rdata`, then assert `mem_we` with the same `mem_addr`. Increment `wr_count` and advance the index. Go to FIN if last, otherwise RD.
- **FIN:** `done=1`, then IDLE.
- **Index advance:** n++; when n wraps past N-1, n=0 and f++. Last index is f=F-1, n=N-1.
- **Raw delta:** 18-bit signed, p=pre[f], q=post[n]:
  - `(p&q ? eta : 0) - (en_post&q&!p ? b_post : 0) - (en_pre&p&!q ? b_pre : 0)`
- **Update:**
  - `delta = raw >>> min(eta_shift,17)`
  - `sum = w + delta`, computed in 18 bits
  - `wdata = sum<wmin ? wmin : sum>wmax ? wmax : sum[15:0]`
  - If wmin>wmax, wdata=wmin.
- Start, enable, and parameter inputs are ignored while busy. Magnitude and gate inputs are sampled live in WR and must be held stable by the user during a pass.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Reset mid-pass aborts immediately. Writes already issued stand and no further strobes are issued.
- **Pass timing:** start accepted at cycle t puts the FSM in RD at t+1.
  - A touched synapse takes 2 cycles (RD, WR).
  - A skipped synapse takes 1 cycle.
  - FIN follows the last synapse.
- **Full pass without skipping:** `done` at t+1+2·F·N. `busy` is high over t+1 .. t+1+2·F·N.
- `mem_re` and `mem_we` are never high in the same cycle.
- `mem_addr` is registered and equal in an RD/WR pair.

## Configuration
- **`STDP_SKIP_IDLE_EN` defined:** a synapse with p=0 and q=0 is skipped in one RD cycle with no `mem_re`/`mem_we`. A pass with all-zero bits takes F·N+1 cycles after acceptance and has `wr_count=0`.
- **Undefined:** no skipping. Every synapse is read and written back (delta 0 writes back the clamped old value), so `wr_count=F·N`.

## Test plan
Use F=2, N=3 unless noted.
- **Reset and clamp:**
  - Reset asserted → all outputs 0.
  - Start with pre=2'b01, post=3'b001, eta=0x0100, shift 0, w[0]=0x3F80, wmax=0x4000 → write addr 0 data 0x4000 (clamped).
- **Depression:** pre=2'b10, post=0, en_pre=1, b_pre=0x0200, shift 1, wmin=-0x4000, w[3..5]=0 → addrs 3,4,5 written 0xFF00.
  - With skip on: wr_count=3 and `done` at t+1+6+3.
- **No skipping (undefined macro):**
  - All bits zero → 6 read/write pairs with unchanged data, `done` at t+13, wr_count=6.
  - Second start while busy is ignored.
- **Gating:**
  - en_post=0 with post=3'b100, pre=0 → written data equals read data.
  - enable=0 with start → stays IDLE, busy=0.
- **Abort and wrap:**
  - rstn low at the WR of addr 2 → no strobes afterwards.
  - Restart completes the pass, and the address sequence 0..5 is checked for f/n wrap.
- **Inverted bounds:** wmin=0x1000, wmax=0x0800 → every write equals 0x1000.
